aes_wb_ctrl: RTL
================

Name: aes_wb_ctrl

Overview:
- Wishbone slave on the Caravel user-project bus that sits directly upstream of the AES core.
- Firmware writes key and plaintext/ciphertext words into the block, then issues a start command.
- The block handshakes the 128-bit operands into the core, waits for completion and captures the result.
- Firmware polls status or takes an interrupt, reads the result back, and reports progress on mprj_io.

Parameters:
- BASE_ADR, 32'h3000_0000: Wishbone base address. Accesses are decoded on adr[31:8] == BASE_ADR[31:8].
- TIMEOUT_CYCLES, 4096: maximum cycles spent in WAIT before the operation is aborted. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- aes_key_o  out  128  key to core
- aes_din_o  out  128  input block to core
- aes_dec_o  out  1  1 = decrypt, 0 = encrypt
- aes_start_o  out  1  one-cycle start pulse
- aes_ready_i  in  1  core idle and able to accept start
- aes_done_i  in  1  one-cycle result-valid pulse
- aes_dout_i  in  128  core result, valid when aes_done_i is high
- irq_o  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Register map (offset = adr[7:0]):
  - 0x00 CTRL: bit0 START (write 1 to request; always reads 0); bit1 DEC (R/W).
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 TIMEOUT (W1C).
  - 0x10–0x1C KEY0..3 (R/W).
  - 0x20–0x2C DIN0..3 (R/W).
  - 0x30–0x3C DOUT0..3 (RO).
  - Word 0 maps to bits [127:96]; word 3 maps to bits [31:0].
  - Unmapped offsets read 0; writes to them are ignored.
- Bus protocol:
  - wbs_ack_o asserts one cycle after the first cycle with cyc & stb & address hit. It is high for exactly one cycle and never asserts on two consecutive cycles.
  - wbs_dat_o is registered and valid only while ack is high; it is 0 otherwise.
  - Writes honour wbs_sel_i per byte.
- Reset values: all registers 0; wbs_ack_o = 0; wbs_dat_o = 0; aes_start_o = 0; irq_o = 0; FSM in IDLE.
- BUSY = pending | (state != IDLE).
  - While BUSY, writes to CTRL, KEY and DIN are acked but discarded.
- FSM states:
  - IDLE: if pending & aes_ready_i, go to ISSUE. A START write sets pending, clears DONE and TIMEOUT, and latches DEC.
  - ISSUE: aes_start_o = 1 for this one cycle; key, din and dec are stable. Clear pending, clear the timeout counter, go to WAIT.
  - WAIT: increment the counter each cycle.
    - On aes_done_i: capture aes_dout_i into DOUT, set DONE, go to IDLE.
    - If the counter reaches TIMEOUT_CYCLES without done: set TIMEOUT, leave DOUT unchanged, go to IDLE.
    - aes_done_i takes priority over timeout when both occur in the same cycle.
- aes_key_o, aes_din_o and aes_dec_o are driven continuously from the registers.
- aes_done_i outside WAIT is ignored.
- Latency: START write ack → aes_start_o is 2 cycles when aes_ready_i is high. aes_done_i → DONE visible on the next read is 1 cycle.
- W1C to DONE in the same cycle hardware sets DONE: DONE stays set. The same rule applies to TIMEOUT.
- Reset asserted mid-operation: return to IDLE on the next edge, clear pending and all registers, suppress any start pulse. A later aes_done_i is ignored.

Optional Feature:
- Macro: AES_WB_IRQ_EN.
- Defined: irq_o = registered (DONE | TIMEOUT) & IRQEN, where IRQEN is CTRL bit2 (R/W, reset 0). irq_o clears one cycle after the W1C.
- Undefined: irq_o is tied to 0, and CTRL bit2 reads 0 and ignores writes.

Test Plan:
- FIPS-197 vector:
  - Stimulus: KEY = 000102030405060708090a0b0c0d0e0f, DIN = 00112233445566778899aabbccddeeff, DEC = 0, START. Core model responds 12 cycles after start.
  - Expected: exactly one aes_start_o pulse 2 cycles after ack; STATUS reads 0x2; DOUT reads 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
- Start while core not ready:
  - Stimulus: aes_ready_i held low for 20 cycles after START.
  - Expected: STATUS = 0x1 throughout; aes_start_o fires 1 cycle after ready rises.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 16, core never asserts done.
  - Expected: STATUS = 0x4 after 16 WAIT cycles; DOUT unchanged; writing 0x4 to STATUS gives 0x0.
- Writes while busy:
  - Stimulus: KEY0 = 0xDEADBEEF and a second START during WAIT.
  - Expected: both acked; KEY0 unchanged; only one aes_start_o pulse.
- Byte lanes and reset:
  - Stimulus: write DIN1 = 0xAABBCCDD with sel = 4'b0101, then assert reset mid-WAIT.
  - Expected: DIN1 reads 0x00BB00DD; after reset all registers read 0 and a late aes_done_i leaves DONE = 0.
- AES_WB_IRQ_EN:
  - Stimulus: IRQEN = 1, run the FIPS vector.
  - Expected: irq_o rises 1 cycle after DONE; W1C drops it. Without the macro, irq_o stays 0.

Source files
------------

// File: rtl/aes_wb_ctrl_if.sv
// Wishbone slave bus bundle for aes_wb_ctrl (Caravel user-project port naming).
interface aes_wb_ctrl_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/aes_wb_ctrl.sv
// Wishbone register front-end for an AES core: operand staging, start handshake, result capture.
// Optional completion interrupt enabled by defining AES_WB_IRQ_EN.
module aes_wb_ctrl #(
   parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   aes_wb_ctrl_if.slave  wb,
   output logic [127:0]  aes_key_o,
   output logic [127:0]  aes_din_o,
   output logic          aes_dec_o,
   output logic          aes_start_o,
   input  logic          aes_ready_i,
   input  logic          aes_done_i,
   input  logic [127:0]  aes_dout_i,
   output logic          irq_o
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             done_set_c, tmo_set_c;
   logic             ack_q, wr_q;
   logic [31:0]      dat_q, wr_dat_q, rdata_c;
   logic [5:0]       wr_word_q, word_c;
   logic [3:0]       wr_sel_q;
   logic [6:0]       wbase_c, rbase_c;
   logic             hit_c, acc_c, busy_c;
   logic             ctrl_wr_c, stat_wr_c, key_wr_c, din_wr_c, start_req_c;
   logic             pending_q, done_q, tmo_q, dec_q, start_q, irqen_c;
   logic [CNT_W-1:0] cnt_q;
   logic [127:0]     key_q, din_q, dout_q;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] sel);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   // Accept one access per ack; the following ack cycle blocks re-acceptance.
   assign hit_c  = wb.wbs_cyc_i && wb.wbs_stb_i && (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
   assign acc_c  = hit_c && !ack_q;
   assign word_c = 6'(wb.wbs_adr_i[7:0] >> 2);
   assign busy_c = pending_q || (state_q != IDLE);

   // Writes commit on the ack cycle from the captured request.
   assign ctrl_wr_c   = wr_q && (wr_word_q == 6'd0) && wr_sel_q[0] && !busy_c;
   assign stat_wr_c   = wr_q && (wr_word_q == 6'd1) && wr_sel_q[0];
   assign key_wr_c    = wr_q && (wr_word_q[5:2] == 4'h1) && !busy_c;
   assign din_wr_c    = wr_q && (wr_word_q[5:2] == 4'h2) && !busy_c;
   assign start_req_c = ctrl_wr_c && wr_dat_q[0];
   assign wbase_c     = {~wr_word_q[1:0], 5'b0};

   always_comb begin
      state_d    = state_q;
      done_set_c = 1'b0;
      tmo_set_c  = 1'b0;
      case (state_q)
         IDLE:  if (pending_q && aes_ready_i) state_d = ISSUE;
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (aes_done_i) begin
               done_set_c = 1'b1;
               state_d    = IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               tmo_set_c = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      rdata_c = '0;
      rbase_c = {~word_c[1:0], 5'b0};
      case (word_c[5:2])
         4'h0: begin
            if (word_c[1:0] == 2'd0)      rdata_c = {29'b0, irqen_c, dec_q, 1'b0};
            else if (word_c[1:0] == 2'd1) rdata_c = {29'b0, tmo_q, done_q, busy_c};
         end
         4'h1:    rdata_c = key_q[rbase_c +: 32];
         4'h2:    rdata_c = din_q[rbase_c +: 32];
         4'h3:    rdata_c = dout_q[rbase_c +: 32];
         default: rdata_c = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q     <= 1'b0;
         dat_q     <= '0;
         wr_q      <= 1'b0;
         wr_word_q <= '0;
         wr_dat_q  <= '0;
         wr_sel_q  <= '0;
      end else begin
         ack_q <= acc_c;
         dat_q <= (acc_c && !wb.wbs_we_i) ? rdata_c : '0;
         wr_q  <= acc_c && wb.wbs_we_i;
         if (acc_c) begin
            wr_word_q <= word_c;
            wr_dat_q  <= wb.wbs_dat_i;
            wr_sel_q  <= wb.wbs_sel_i;
         end
      end
   end

   // Control, status and operand registers; hardware set wins over W1C.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         pending_q <= 1'b0;
         done_q    <= 1'b0;
         tmo_q     <= 1'b0;
         dec_q     <= 1'b0;
         start_q   <= 1'b0;
         cnt_q     <= '0;
         key_q     <= '0;
         din_q     <= '0;
         dout_q    <= '0;
      end else begin
         start_q <= (state_d == ISSUE);
         if (start_req_c)          pending_q <= 1'b1;
         else if (state_q == ISSUE) pending_q <= 1'b0;
         cnt_q  <= (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
         done_q <= done_set_c || (done_q && !(stat_wr_c && wr_dat_q[1]) && !start_req_c);
         tmo_q  <= tmo_set_c || (tmo_q && !(stat_wr_c && wr_dat_q[2]) && !start_req_c);
         if (done_set_c) dout_q <= aes_dout_i;
         if (ctrl_wr_c)  dec_q <= wr_dat_q[1];
         if (key_wr_c) key_q[wbase_c +: 32] <= merge_bytes(key_q[wbase_c +: 32], wr_dat_q, wr_sel_q);
         if (din_wr_c) din_q[wbase_c +: 32] <= merge_bytes(din_q[wbase_c +: 32], wr_dat_q, wr_sel_q);
      end
   end

`ifdef AES_WB_IRQ_EN
   logic irqen_q, irq_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         irqen_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         if (ctrl_wr_c) irqen_q <= wr_dat_q[2];
         irq_q <= (done_q || tmo_q) && irqen_q;
      end
   end

   assign irqen_c = irqen_q;
   assign irq_o   = irq_q;
`else
   assign irqen_c = 1'b0;
   assign irq_o   = 1'b0;
`endif

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;
   assign aes_key_o    = key_q;
   assign aes_din_o    = din_q;
   assign aes_dec_o    = dec_q;
   assign aes_start_o  = start_q;
endmodule
